eff_clip_pipe: RTL

Parametrised, pipelined distortion/limiter stage for the PCM audio effect chain; the next generation of the single-mode hard clipper. Applies a programmable pre-gain, then bypass, hard-clip or soft-knee clip against a programmable threshold. Sits between the PCM sample source (valid strobe per sample) and the output serialiser, with a fixed latency.

---
 rtl/eff_pkg.sv | 26 ++
 rtl/eff_clip_pipe_sat.sv | 29 ++
 rtl/eff_clip_pipe.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/eff_pkg.sv
// Shared types and constants for the PCM clip/limiter effect stage.
// Contents: clip mode encoding, config payload (at the default sample/gain
// widths), Q4.4 gain constants.
package eff_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_HARD   = 2'b01,
    MODE_SOFT   = 2'b10,
    MODE_RSVD   = 2'b11
  } clip_mode_e;

  localparam int unsigned GAIN_FRAC_BITS = 4;
  localparam int unsigned GAIN_UNITY     = 16;  // 1.0 in Q4.4

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_GAIN_W = 8;

  // Config payload for a default-width instance (16-bit samples, Q4.4 gain)
  typedef struct packed {
    clip_mode_e              mode;
    logic [DEF_GAIN_W-1:0]   gain;
    logic [DEF_WIDTH-2:0]    threshold;
  } cfg_t;

endpackage

// File: rtl/eff_clip_pipe_sat.sv
// Combinational symmetric signed saturator.
// Ports: din (IN_W signed) -> dout (OUT_W signed) clamped to
// +/-(2^(OUT_W-1)-1); sat is high when clamping took place.
// Note: the most negative OUT_W code is never produced.
module eff_sat #(
  parameter int unsigned IN_W  = 25,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'({(OUT_W-1){1'b1}});
  localparam logic signed [IN_W-1:0] MIN_V = -MAX_V;

  always_comb begin
    sat  = 1'b0;
    dout = din[OUT_W-1:0];
    if (din > MAX_V) begin
      sat  = 1'b1;
      dout = MAX_V[OUT_W-1:0];
    end else if (din < MIN_V) begin
      sat  = 1'b1;
      dout = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/eff_clip_pipe.sv
// Pipelined pre-gain + bypass/hard/soft-knee clipper for the PCM effect chain.
// Latency: in_valid sampled at edge N -> out_valid after edge N+3.
// Ports:
//   clk_25mhz, rst (async, active-high)
//   in_valid/audio_in          : input sample strobe + signed sample
//   cfg_load/mode/gain/threshold: shadow config capture
//   out_valid/audio_out/clip_flag: processed sample (audio_out holds when idle)
//   process_status             : any pipeline stage holds a valid sample
//   clip_count                 : saturating clip-event counter, only when
//                                EFF_CLIP_STATS_EN is defined
module eff_clip_pipe
  import eff_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned GAIN_W     = 8,
  parameter int unsigned KNEE_SHIFT = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk_25mhz,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] audio_in,
  input  logic                    cfg_load,
  input  logic [1:0]              mode,
  input  logic [GAIN_W-1:0]       gain,
  input  logic [WIDTH-2:0]        threshold,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] audio_out,
  output logic                    clip_flag,
  output logic                    process_status
`ifdef EFF_CLIP_STATS_EN
  ,
  output logic [CNT_W-1:0]        clip_count
`endif
);

  localparam int unsigned PROD_W = WIDTH + GAIN_W + 1;
  localparam int unsigned MAG_W  = WIDTH + 1;
  localparam int unsigned CLIP_W = WIDTH + 2;

  if (CNT_W < 1 || WIDTH < 2) begin : g_param_err
    $error("eff_clip_pipe: CNT_W must be >= 1 and WIDTH >= 2");
  end

  typedef struct packed {
    clip_mode_e          mode;
    logic [GAIN_W-1:0]   gain;
    logic [WIDTH-2:0]    threshold;
  } pipe_cfg_t;

  pipe_cfg_t               shadow;
  pipe_cfg_t               s1_cfg;
  logic                    s1_valid;
  logic signed [WIDTH-1:0] s1_x;

  logic                    s2_valid;
  logic signed [WIDTH-1:0] s2_x;
  logic                    s2_sat;
  clip_mode_e              s2_mode;
  logic [WIDTH-2:0]        s2_thr;

  logic                    s3_valid;
  logic signed [WIDTH-1:0] s3_y;
  logic                    s3_flag;

  // S2 datapath: signed sample times unsigned Q4.4 gain, drop the fraction
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_sh;
  logic signed [WIDTH-1:0]  gained;
  logic                     gain_sat;

  assign prod    = PROD_W'(s1_x) * PROD_W'($signed({1'b0, s1_cfg.gain}));
  assign prod_sh = prod >>> GAIN_FRAC_BITS;

  eff_sat #(.IN_W(PROD_W), .OUT_W(WIDTH)) u_sat_gain (
    .din  (prod_sh),
    .dout (gained),
    .sat  (gain_sat)
  );

  // S3 datapath: magnitude compare against threshold, rebuild signed result
  logic signed [MAG_W-1:0]  x_ext;
  logic [MAG_W-1:0]         mag;
  logic [MAG_W-1:0]         thr_ext;
  logic [MAG_W-1:0]         knee_mag;
  logic [MAG_W-1:0]         lim_mag;
  logic signed [CLIP_W-1:0] lim_s;
  logic signed [CLIP_W-1:0] clip_pre;
  logic signed [WIDTH-1:0]  clip_y;
  logic                     clip_sat;
  logic                     x_neg;
  logic                     over;
  logic                     clip_evt;

  always_comb begin
    x_neg    = s2_x[WIDTH-1];
    x_ext    = MAG_W'(s2_x);
    mag      = x_neg ? MAG_W'(-x_ext) : MAG_W'(x_ext);
    thr_ext  = MAG_W'(s2_thr);
    over     = mag > thr_ext;
    // only meaningful when over=1; the subtraction wraps otherwise
    knee_mag = thr_ext + ((mag - thr_ext) >> KNEE_SHIFT);
    lim_mag  = thr_ext;
    clip_evt = 1'b0;
    case (s2_mode)
      MODE_BYPASS: lim_mag = mag;
      MODE_SOFT:   begin lim_mag = knee_mag; clip_evt = over; end
      default:     begin lim_mag = thr_ext;  clip_evt = over; end
    endcase
    lim_s    = $signed(CLIP_W'(lim_mag));
    clip_pre = clip_evt ? (x_neg ? -lim_s : lim_s) : CLIP_W'(s2_x);
  end

  eff_sat #(.IN_W(CLIP_W), .OUT_W(WIDTH)) u_sat_clip (
    .din  (clip_pre),
    .dout (clip_y),
    .sat  (clip_sat)
  );

  // Shadow config and pipeline registers
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      shadow         <= '{mode: MODE_BYPASS, gain: GAIN_W'(GAIN_UNITY), threshold: '1};
      s1_cfg         <= '{mode: MODE_BYPASS, gain: GAIN_W'(GAIN_UNITY), threshold: '1};
      s1_valid       <= 1'b0;
      s1_x           <= '0;
      s2_valid       <= 1'b0;
      s2_x           <= '0;
      s2_sat         <= 1'b0;
      s2_mode        <= MODE_BYPASS;
      s2_thr         <= '1;
      s3_valid       <= 1'b0;
      s3_y           <= '0;
      s3_flag        <= 1'b0;
      out_valid      <= 1'b0;
      audio_out      <= '0;
      clip_flag      <= 1'b0;
      process_status <= 1'b0;
    end else begin
      if (cfg_load) begin
        shadow <= '{mode: clip_mode_e'(mode), gain: gain, threshold: threshold};
      end
      // a sample on the cfg_load edge still sees the old shadow value
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x   <= audio_in;
        s1_cfg <= shadow;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_x    <= gained;
        s2_sat  <= gain_sat;
        s2_mode <= s1_cfg.mode;
        s2_thr  <= s1_cfg.threshold;
      end
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_y    <= clip_y;
        s3_flag <= s2_sat | clip_evt | clip_sat;
      end
      out_valid <= s3_valid;
      clip_flag <= s3_valid & s3_flag;
      if (s3_valid) begin
        audio_out <= s3_y;
      end
      // registered form of OR(s1..s3 valid) as they will be after this edge
      process_status <= in_valid | s1_valid | s2_valid;
    end
  end

`ifdef EFF_CLIP_STATS_EN
  // Saturating clip-event counter, cleared by any config load
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      clip_count <= '0;
    end else if (cfg_load) begin
      clip_count <= '0;
    end else if (out_valid && clip_flag && (clip_count != '1)) begin
      clip_count <= clip_count + CNT_W'(1);
    end
  end
`endif

endmodule
